// File: rtl/score_disp_pkg.sv
// Shared constants and types for the seven-segment score display.
// All segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package score_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Scan slot: 0 = rightmost digit, 3 = leftmost digit.
    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes (10..15) are shown as a dash so bad upstream data is visible.
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Map each BCD value onto its segment pattern.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_scan_driver.sv
// Four-digit time-multiplexed score display driver.
// Scans p2 ones/tens and p1 ones/tens onto a common-anode display
// (anodes and segments active-low), with optional leading-zero blanking
// of the tens digits and a frame-counter driven game-over flash.
module score_scan_driver
    import score_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int FLASH_BIT   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] p1_tens,
    input  logic [3:0] p1_ones,
    input  logic [3:0] p2_tens,
    input  logic [3:0] p2_ones,
    input  logic       blank_lz,
    input  logic       flash_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Prescaler width; at least one bit even for the smallest divider.
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q,   idx_d;
    logic [7:0]    frame_q, frame_d;
    logic [3:0]    an_q,    an_d;
    logic [6:0]    seg_q,   seg_d;

    logic       tick;
    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       lz_blank;
    logic       flash_dark;

    assign tick = (presc_q == PRESC_LAST);

    // Scan timing: prescaler wraps every REFRESH_DIV cycles, slot advances on
    // each wrap, and the frame counter advances when the last slot ends.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? idx_q + 1'b1 : idx_q;
        frame_d = (tick && idx_q == 2'd3) ? frame_q + 8'd1 : frame_q;
    end

    // Select the digit shown in the current slot.
    always_comb begin
        digit = p2_ones;
        case (idx_q)
            2'd0: digit = p2_ones;
            2'd1: digit = p2_tens;
            2'd2: digit = p1_ones;
            2'd3: digit = p1_tens;
            default: digit = p2_ones;
        endcase
    end

    seg7_decode u_decode (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    // Odd slots carry the tens digits; only those may be blanked.
    assign lz_blank   = blank_lz && idx_q[0] && (digit == 4'd0);
    assign flash_dark = flash_en && frame_q[FLASH_BIT];

    // Next anode/segment values: one-hot-low anode unless blanked or flashed off.
    always_comb begin
        an_d  = ~(4'(1) << idx_q);
        seg_d = digit_seg;
        if (lz_blank || flash_dark) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    // Decimal point is reserved and always off.
    assign dp  = 1'b1;

endmodule
